mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS-lite datapath: addu, subu, ori, lw, sw, beq, lui, j.
- Sequences one shared ALU and one shared memory over several cycles per instruction, replacing the single-cycle decoder.
- Issues per-state datapath enables, ALU control and a memory request/acknowledge handshake.
- Counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_ctrl_dec.sv | 38 +++
 rtl/mc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the mc_ctrl multi-cycle control FSM: states, opcodes,
// funct codes, ALU controls and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_R     = 4'd7,
    ST_WB_I     = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_CMP  = 4'd4;
  localparam logic [3:0] ALU_LUI  = 4'd5;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFF = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_MEM = 3'd2,
    CLS_BR  = 3'd3,
    CLS_J   = 3'd4,
    CLS_ILL = 3'd5
  } iclass_t;

  // alt selects the second member of a class: subu, lui or sw
  typedef struct packed {
    iclass_t cls;
    logic    alt;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational opcode/funct to instruction-class decode for mc_ctrl.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec.cls = CLS_ILL;
    o_dec.alt = 1'b0;
    unique case (i_op)
      OP_RTYPE: begin
        if (i_funct == FN_ADDU) begin
          o_dec.cls = CLS_R;
        end else if (i_funct == FN_SUBU) begin
          o_dec.cls = CLS_R;
          o_dec.alt = 1'b1;
        end
      end
      OP_ORI:  o_dec.cls = CLS_I;
      OP_LUI: begin
        o_dec.cls = CLS_I;
        o_dec.alt = 1'b1;
      end
      OP_LW:   o_dec.cls = CLS_MEM;
      OP_SW: begin
        o_dec.cls = CLS_MEM;
        o_dec.alt = 1'b1;
      end
      OP_BEQ:  o_dec.cls = CLS_BR;
      OP_J:    o_dec.cls = CLS_J;
      default: o_dec.cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-lite control FSM with retired-instruction counter.
// MC_CTRL_ILLEGAL_TRAP_EN: undecoded instructions halt and raise illegal.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             i_or_d,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctl,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  state_t           r_state;
  state_t           w_next;
  dec_t             w_dec;
  logic             w_retire;
  logic [CNT_W-1:0] r_instret;

  // zero is consumed by the datapath; immediate/register fields are not needed here
  logic w_unused;
  assign w_unused = zero ^ (^instruction[25:6]);

  mc_ctrl_dec u_dec (
    .i_op    (instruction[31:26]),
    .i_funct (instruction[5:0]),
    .o_dec   (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    unique case (r_state)
      ST_FETCH: if (mem_ack) w_next = ST_DECODE;
      ST_DECODE: begin
        unique case (w_dec.cls)
          CLS_R:   w_next = ST_EXEC_R;
          CLS_I:   w_next = ST_EXEC_I;
          CLS_MEM: w_next = ST_MEM_ADDR;
          CLS_BR:  w_next = ST_BRANCH;
          CLS_J:   w_next = ST_JUMP;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            w_next   = ST_HALT;
`else
            w_next   = ST_FETCH;
            w_retire = 1'b1;
`endif
          end
        endcase
      end
      ST_EXEC_R:   w_next = ST_WB_R;
      ST_EXEC_I:   w_next = ST_WB_I;
      ST_MEM_ADDR: w_next = w_dec.alt ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ack) w_next = ST_WB_MEM;
      ST_MEM_WR: begin
        if (mem_ack) begin
          w_next   = ST_FETCH;
          w_retire = 1'b1;
        end
      end
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    i_or_d        = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_ctl       = ALU_ADD;
    pc_source     = PCSRC_ALU;
    unique case (r_state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      ST_DECODE: alu_src_b = SRCB_BOFF;
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_ctl   = w_dec.alt ? ALU_SUB : ALU_ADD;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctl   = w_dec.alt ? ALU_LUI : ALU_OR;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_WB_I: reg_write = 1'b1;
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctl       = ALU_CMP;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: begin
      end
    endcase
  end

  assign state   = r_state;
  assign instret = r_instret;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (r_state == ST_HALT);
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a 32-bit and a 4-bit counter instance share stimulus.
module tb_mc_ctrl;

  localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_ER = 4'd2, S_EI = 4'd3,
                         S_MA = 4'd4, S_MR = 4'd5, S_MW = 4'd6, S_WR = 4'd7,
                         S_WI = 4'd8, S_WM = 4'd9, S_BR = 4'd10, S_J = 4'd11,
                         S_H = 4'd12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;

  logic mem_req, i_or_d, mem_write, ir_write, pc_write, pc_write_cond;
  logic reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_ctl, state;
  logic [31:0] instret;

  logic mem_req4, i_or_d4, mem_write4, ir_write4, pc_write4, pc_write_cond4;
  logic reg_write4, reg_dst4, mem_to_reg4, alu_src_a4;
  logic [1:0] alu_src_b4, pc_source4;
  logic [3:0] alu_ctl4, state4;
  logic [3:0] instret4;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal, illegal4;
`endif

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .i_or_d(i_or_d),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctl(alu_ctl), .pc_source(pc_source), .state(state), .instret(instret)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  mc_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req4), .i_or_d(i_or_d4),
    .mem_write(mem_write4), .ir_write(ir_write4), .pc_write(pc_write4),
    .pc_write_cond(pc_write_cond4), .reg_write(reg_write4), .reg_dst(reg_dst4),
    .mem_to_reg(mem_to_reg4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
    .alu_ctl(alu_ctl4), .pc_source(pc_source4), .state(state4), .instret(instret4)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal4)
`endif
  );

  logic [21:0] act, act4;
  assign act  = {state, mem_req, i_or_d, mem_write, ir_write, pc_write,
                 pc_write_cond, reg_write, reg_dst, mem_to_reg, alu_src_a,
                 alu_src_b, alu_ctl, pc_source};
  assign act4 = {state4, mem_req4, i_or_d4, mem_write4, ir_write4, pc_write4,
                 pc_write_cond4, reg_write4, reg_dst4, mem_to_reg4, alu_src_a4,
                 alu_src_b4, alu_ctl4, pc_source4};

  typedef struct {
    logic        ack;
    logic [31:0] ins;
    logic [3:0]  st;
    bit          retire;
  } ent_t;

  ent_t        q[$];
  int unsigned errs = 0;
  int unsigned checks = 0;
  logic [31:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic [31:0] ins,
                                          input logic ack);
    logic req, iod, mw, irw, pw, pwc, rw, rd, m2r, sa;
    logic [1:0] sb, ps;
    logic [3:0] ac;
    {req, iod, mw, irw, pw, pwc, rw, rd, m2r, sa} = '0;
    sb = 2'd0; ps = 2'd0; ac = 4'd0;
    case (st)
      S_F:  begin req = 1'b1; sb = 2'd1; irw = ack; pw = ack; end
      S_D:  sb = 2'd3;
      S_ER: begin sa = 1'b1; ac = (ins[5:0] == 6'h23) ? 4'd1 : 4'd0; end
      S_EI: begin sa = 1'b1; sb = 2'd2; ac = (ins[31:26] == 6'h0f) ? 4'd5 : 4'd3; end
      S_MA: begin sa = 1'b1; sb = 2'd2; end
      S_MR: begin req = 1'b1; iod = 1'b1; end
      S_MW: begin req = 1'b1; iod = 1'b1; mw = 1'b1; end
      S_WR: begin rw = 1'b1; rd = 1'b1; end
      S_WI: rw = 1'b1;
      S_WM: begin rw = 1'b1; m2r = 1'b1; end
      S_BR: begin sa = 1'b1; ac = 4'd4; pwc = 1'b1; ps = 2'd1; end
      S_J:  begin pw = 1'b1; ps = 2'd2; end
      default: ;
    endcase
    return {st, req, iod, mw, irw, pw, pwc, rw, rd, m2r, sa, sb, ac, ps};
  endfunction

  task automatic push(input logic [3:0] st, input logic [31:0] ins, input logic ack,
                      input bit retire);
    ent_t e;
    e.st = st; e.ins = ins; e.ack = ack; e.retire = retire;
    q.push_back(e);
  endtask

  // Called at posedge+1; leaves at posedge+1 of the cycle after the last entry.
  task automatic drain();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ack     = e.ack;
      instruction = e.ins;
      @(negedge clk);
      chk("vec32", {10'd0, act},  {10'd0, exp_vec(e.st, e.ins, e.ack)});
      chk("vec4",  {10'd0, act4}, {10'd0, exp_vec(e.st, e.ins, e.ack)});
      chk("instret32", instret, exp_cnt);
      chk("instret4", {28'd0, instret4}, {28'd0, exp_cnt[3:0]});
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      chk("illegal", {31'd0, illegal}, {31'd0, (e.st == S_H)});
`endif
      @(posedge clk);
      if (e.retire) exp_cnt++;
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_instret4", {28'd0, instret4}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic run(input logic [31:0] ins, input int unsigned fwaits,
                     input int unsigned mwaits);
    logic [5:0] op, fn;
    bit         halted;
    op = ins[31:26];
    fn = ins[5:0];
    halted = 1'b0;
    for (int unsigned i = 0; i < fwaits; i++) push(S_F, ins, 1'b0, 1'b0);
    push(S_F, ins, 1'b1, 1'b0);
    if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
      push(S_D, ins, 1'b1, 1'b0); push(S_ER, ins, 1'b1, 1'b0); push(S_WR, ins, 1'b1, 1'b1);
    end else if (op == 6'h0d || op == 6'h0f) begin
      push(S_D, ins, 1'b1, 1'b0); push(S_EI, ins, 1'b1, 1'b0); push(S_WI, ins, 1'b1, 1'b1);
    end else if (op == 6'h23) begin
      push(S_D, ins, 1'b1, 1'b0); push(S_MA, ins, 1'b1, 1'b0);
      for (int unsigned i = 0; i < mwaits; i++) push(S_MR, ins, 1'b0, 1'b0);
      push(S_MR, ins, 1'b1, 1'b0); push(S_WM, ins, 1'b1, 1'b1);
    end else if (op == 6'h2b) begin
      push(S_D, ins, 1'b1, 1'b0); push(S_MA, ins, 1'b1, 1'b0);
      for (int unsigned i = 0; i < mwaits; i++) push(S_MW, ins, 1'b0, 1'b0);
      push(S_MW, ins, 1'b1, 1'b1);
    end else if (op == 6'h04) begin
      push(S_D, ins, 1'b1, 1'b0); push(S_BR, ins, 1'b1, 1'b1);
    end else if (op == 6'h02) begin
      push(S_D, ins, 1'b1, 1'b0); push(S_J, ins, 1'b1, 1'b1);
    end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      push(S_D, ins, 1'b1, 1'b0);
      for (int unsigned i = 0; i < 10; i++) push(S_H, ins, 1'b1, 1'b0);
      halted = 1'b1;
`else
      push(S_D, ins, 1'b1, 1'b1);
`endif
    end
    drain();
    if (halted) do_reset();
  endtask

  initial begin
    do_reset();
    run(32'h00221821, 0, 0);  // addu
    run(32'h8C220004, 0, 2);  // lw, two wait states
    run(32'h10220003, 0, 0);  // beq
    run(32'hAC220000, 1, 1);  // sw, fetch and store waits
    run(32'h08000010, 0, 0);  // j
    run(32'h00221823, 0, 0);  // subu
    run(32'h342200FF, 0, 0);  // ori
    run(32'h3C011234, 0, 0);  // lui
    run(32'hFC000000, 0, 0);  // opcode 0x3f
    run(32'h00221820, 0, 0);  // add funct, undecoded

    // reset asserted while a store waits for its ack
    do_reset();
    push(S_F, 32'hAC220000, 1'b1, 1'b0);
    push(S_D, 32'hAC220000, 1'b1, 1'b0);
    push(S_MA, 32'hAC220000, 1'b1, 1'b0);
    push(S_MW, 32'hAC220000, 1'b0, 1'b0);
    push(S_MW, 32'hAC220000, 1'b0, 1'b0);
    drain();
    chk("mw_before_rst", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {28'd0, state}, 32'd0);
    chk("midrst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("midrst_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = '0;
    push(S_F, 32'h08000010, 1'b1, 1'b0);
    push(S_D, 32'h08000010, 1'b1, 1'b0);
    push(S_J, 32'h08000010, 1'b1, 1'b1);
    drain();

    do_reset();
    for (int i = 0; i < 16; i++) run(32'h08000010, 0, 0);
    @(negedge clk);
    chk("wrap_instret32", instret, 32'd16);
    chk("wrap_instret4", {28'd0, instret4}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
